serial_digit_adder: RTL and testbench
=====================================

SERIAL_DIGIT_ADDER -- requirements
Module: serial_digit_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per cycle; WIDTH mod DIGIT SHALL be 0, else elaboration error.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Port order: clk then rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand request.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  addend A.
REQ-009 b  input  WIDTH  addend B.
REQ-010 cin  input  1  carry in.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  final carry out.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; DIGITS = WIDTH/DIGIT.
REQ-017 IDLE: in_ready=1. When in_valid=1, SHALL latch a, b, cin, clear the digit counter and go to RUN.
REQ-018 RUN: each cycle SHALL add one DIGIT-bit slice of a and b, least significant slice first, together with the carry register. It SHALL store the slice sum into sum[k*DIGIT +: DIGIT] and the slice carry into the carry register.
REQ-019 On the last slice (counter = DIGITS-1), SHALL go to DONE. out_valid SHALL rise exactly DIGITS cycles after the accepting edge.
REQ-020 DONE: out_valid=1; sum and cout SHALL hold stable until out_ready=1. The transfer edge SHALL return to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE. in_valid there SHALL be ignored, and latched operands SHALL be unaffected.
REQ-022 The result handshake SHALL NOT overlap with a new accept. The minimum issue interval SHALL be DIGITS+2 cycles.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH. cout SHALL be bit WIDTH of a+b+cin.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 The DIGIT=WIDTH boundary case SHALL be legal, with a single RUN cycle.

Reset
REQ-026 rst=1 SHALL force IDLE from any state, including mid-RUN and DONE. The partial result SHALL be discarded.
REQ-027 Reset values: in_ready=0 during the reset cycle, then 1; out_valid=0, sum=0, cout=0, busy=0, counter=0, carry register=0.
REQ-028 Operand registers need no reset.

Configuration
REQ-029 Macro SERIAL_DIGIT_ADDER_SUB_EN SHALL control subtraction support.
REQ-030 Defined: SHALL add input port sub (1 bit), latched at accept. When sub=1, the result SHALL be a + ~b + 1 and cin SHALL be ignored. cout=1 SHALL mean no borrow.
REQ-031 Undefined: the sub port SHALL be absent, and behaviour SHALL be addition only.

Structure
REQ-032 Package serial_digit_adder_pkg SHALL hold the state enum type and a function computing DIGITS and the counter width ($clog2, minimum 1).
REQ-033 Sub-module ripple_digit_adder SHALL be a combinational DIGIT-bit ripple adder (a, b, ci -> s, co), built as a chain of full-adder cells. It SHALL be instantiated once.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-034 a=0x1234, b=0x4321, cin=0 -> after 4 RUN cycles sum=0x5555, cout=0; out_valid high on cycle 4 after accept.
REQ-035 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Separately, a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
REQ-036 out_ready held 0 for 3 cycles in DONE -> sum and cout stable, in_ready=0, a new in_valid is ignored. After out_ready=1, IDLE and in_ready=1 next cycle.
REQ-037 rst pulsed on the 2nd RUN cycle -> next cycle IDLE, sum=0, out_valid=0. A following accept of 0x0001+0x0001 gives sum=0x0002.
REQ-038 With SERIAL_DIGIT_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Also sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-039 With WIDTH=8, DIGIT=8: 0xF0+0x0F+cin=1 -> sum=0x00, cout=1, one RUN cycle.

Source files
------------

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// SERIAL_DIGIT_ADDER_SUB_EN in the top enables subtraction.
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int calc_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder.
// Built from a chain of full-adder cells.
module ripple_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic p;
        assign p      = a[i] ^ b[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: one DIGIT-bit slice per cycle, LS slice first.
// Define SERIAL_DIGIT_ADDER_SUB_EN to add the sub port (a - b).
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int DIGITS = calc_digits(WIDTH, DIGIT);
    localparam int CNT_W  = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_cfg
        $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             last;
    logic             cin_eff;
    logic [DIGIT-1:0] sl_a;
    logic [DIGIT-1:0] sl_b;
    logic [DIGIT-1:0] sl_s;
    logic             sl_co;

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    logic sub_r;

    // a - b is a + ~b + 1, so cin is replaced by a forced carry.
    assign cin_eff = sub ? 1'b1 : cin;
    assign sl_b    = sub_r ? ~b_r[cnt*DIGIT +: DIGIT]
                           :  b_r[cnt*DIGIT +: DIGIT];
`else
    assign cin_eff = cin;
    assign sl_b    = b_r[cnt*DIGIT +: DIGIT];
`endif

    assign sl_a = a_r[cnt*DIGIT +: DIGIT];
    assign last = (cnt == LAST);

    ripple_digit_adder #(
        .DIGIT(DIGIT)
    ) u_rda (
        .a (sl_a),
        .b (sl_b),
        .ci(carry),
        .s (sl_s),
        .co(sl_co)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // Operand registers are deliberately left out of the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
                        sub_r  <= sub;
`endif
                        carry  <= cin_eff;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_r[cnt*DIGIT +: DIGIT] <= sl_s;
                    carry <= sl_co;
                    if (last) begin
                        cnt    <= '0;
                        cout_r <= sl_co;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder (16/4 and 8/8 builds).
// Subtraction vectors run when SERIAL_DIGIT_ADDER_SUB_EN is defined.
module tb_serial_digit_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        sub8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        busy8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .a        (a8),
        .b        (b8),
        .cin      (cin8),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub      (sub8),
`endif
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .sum      (sum8),
        .cout     (cout8),
        .busy     (busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept, check 4-cycle latency and result, then drain.
    task automatic run16(input string tag, input logic [15:0] va,
                         input logic [15:0] vb, input logic vc,
                         input logic vs, input logic [15:0] es,
                         input logic ec);
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        sub = vs;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, "_ovalid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b0;
        in_valid8 = 1'b0;
        a8 = '0;
        b8 = '0;
        cin8 = 1'b0;
        sub8 = 1'b0;
        out_ready8 = 1'b0;
        step();
        step();
        check("rst_iready", {31'd0, in_ready}, 32'd0);
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_iready", {31'd0, in_ready}, 32'd1);

        run16("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        run16("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        run16("msb_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        run16("ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

        // Stall in DONE with a new request that must be ignored.
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        out_ready = 1'b1;
        step();
        a = 16'hFFFF;
        b = 16'hFFFF;
        cin = 1'b1;
        step();
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_iready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b0;
        step();
        step();
        step();
        check("stall_ovalid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_sum", {16'd0, sum}, 32'h3333);
            check("stall_cout", {31'd0, cout}, 32'd0);
            check("stall_iready", {31'd0, in_ready}, 32'd0);
            check("stall_ovalid_hold", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("xfer_iready", {31'd0, in_ready}, 32'd1);
        check("xfer_ovalid", {31'd0, out_valid}, 32'd0);
        check("xfer_busy", {31'd0, busy}, 32'd0);

        // Reset during the second RUN cycle discards the partial sum.
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_iready", {31'd0, in_ready}, 32'd1);
        run16("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        run16("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run16("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        run16("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        sub = 1'b0;
`endif

        // Single-digit build: result one cycle after accept.
        in_valid8 = 1'b1;
        a8 = 8'hF0;
        b8 = 8'h0F;
        cin8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        check("w8_busy", {31'd0, busy8}, 32'd1);
        check("w8_early", {31'd0, out_valid8}, 32'd0);
        step();
        check("w8_ovalid", {31'd0, out_valid8}, 32'd1);
        check("w8_sum", {24'd0, sum8}, 32'h00);
        check("w8_cout", {31'd0, cout8}, 32'd1);
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        check("w8_iready", {31'd0, in_ready8}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
